memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The module SHALL have parameter MEM_LATENCY, default 4, the memory access time in cycles; legal range 1..255.
REQ-002 The module SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have input reset, 1 bit, synchronous and active-high.
REQ-004 The module SHALL have instruction-port inputs: i_req (1), a read request, and i_addr (32), the read address.
REQ-005 The module SHALL have instruction-port outputs: i_data_out (4x8, bytes [0:3]), the read data, and i_ready (1), the completion pulse.
REQ-006 The module SHALL have data-port inputs: d_req (1), d_addr (32), d_data_in (4x8), d_write_enable (1) and d_byte_mode (1).
REQ-007 The module SHALL have data-port outputs: d_data_out (4x8), the read data, and d_ready (1), the completion pulse.
REQ-008 The module SHALL have input mem_data_out (4x8), the memory read data.
REQ-009 The module SHALL have memory-side outputs: output_mem_addr (32), mem_data_in (4x8), mem_write_en (1) and mem_byte_mode (1).
REQ-010 The module SHALL have status outputs: busy (1), high while not IDLE, and grant (1), the current or last owner (0 = instruction, 1 = data).

Function
REQ-011 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-012 In IDLE, if any request is high at rising edge k, the FSM SHALL choose a winner, latch its addr/data/write/byte_mode, load counter = MEM_LATENCY-1 and enter ACCESS.
REQ-013 A single request SHALL always be granted.
REQ-014 When both requests are high, the port not equal to last_grant SHALL win (round-robin); last_grant SHALL update on every grant.
REQ-015 While in ACCESS, output_mem_addr, mem_data_in and mem_byte_mode SHALL be driven from the latched values.
REQ-016 In ACCESS the counter SHALL decrement each cycle; when it reaches 0, that cycle SHALL be the final ACCESS cycle.
REQ-017 mem_write_en SHALL be high only in the final ACCESS cycle, and only for a latched data-port write; the instruction port never writes.
REQ-018 On the final ACCESS cycle of a read, mem_data_out SHALL be captured into the owner's data_out register; the other port's data_out SHALL be unchanged.
REQ-019 After ACCESS the FSM SHALL enter DONE for exactly one cycle, asserting the owner's ready; the owner's ready is high in cycle k+MEM_LATENCY, where edge k is the grant.
REQ-020 The FSM SHALL go from DONE to IDLE unconditionally; requests SHALL NOT be sampled in ACCESS or DONE.
REQ-021 Requesters SHALL hold req and their signals stable until ready, then deassert req or present a new request the cycle after ready; the earliest regrant is one cycle after DONE.
REQ-022 For a write, d_ready SHALL also pulse in DONE, and d_data_out SHALL be unchanged.
REQ-023 data_out registers SHALL hold their value until that port's next completed read.
REQ-024 Addresses SHALL be forwarded unmodified, with no alignment check.
REQ-025 Outside ACCESS, output_mem_addr, mem_data_in and mem_byte_mode SHALL hold their last values; mem_write_en SHALL be 0.
REQ-026 i_ready and d_ready SHALL never both be high in the same cycle.

Reset
REQ-027 When reset is high at an edge: state = IDLE, counter = 0, last_grant = 1 (so port 0 wins the first tie), grant = 0, busy = 0, both ready = 0, mem_write_en = 0, mem_byte_mode = 0, output_mem_addr = 0, mem_data_in = 0, and both data_out = 0.
REQ-028 Reset during ACCESS or DONE SHALL abort the access: no ready pulse, and mem_write_en low from the next cycle; the pending request SHALL be re-arbitrated only after reset deasserts.
REQ-029 Reset SHALL take priority over all other transitions.

Verification
REQ-030 Single instruction read: MEM_LATENCY=4, i_req with i_addr=0x00000040, memory returns {DE,AD,BE,EF} -> i_ready is a single pulse 4 cycles after grant, and i_data_out = {DE,AD,BE,EF}.
REQ-031 Data write: d_req, d_write_enable=1, d_addr=0x100, d_data_in={01,02,03,04} -> mem_write_en is high exactly 1 cycle (the final ACCESS cycle) with output_mem_addr=0x100 and mem_data_in={01,02,03,04}; then d_ready pulses.
REQ-032 Simultaneous requests held from reset -> grants alternate I, D, I, D; each port completes once per two transactions, and the ready pulses are never coincident.
REQ-033 Reset asserted on the 2nd ACCESS cycle of a write -> no d_ready, no mem_write_en pulse, and all outputs at their REQ-027 values on the next cycle.
REQ-034 MEM_LATENCY=1 back-to-back d_req reads -> ready pulses every 3 cycles, and d_out updates each time while i_data_out stays unchanged.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency memory.
// The instruction port only reads; the data port reads or writes.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// ACCESS | memory cycle in progress; counter counts down to the final cycle
// DONE   | one-cycle completion; owner's ready is asserted
module memory_arbiter #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic [0:3][7:0] i_data_out,
  output logic            i_ready,
  input  logic            d_req,
  input  logic [31:0]     d_addr,
  input  logic [0:3][7:0] d_data_in,
  input  logic            d_write_enable,
  input  logic            d_byte_mode,
  output logic [0:3][7:0] d_data_out,
  output logic            d_ready,
  input  logic [0:3][7:0] mem_data_out,
  output logic [31:0]     output_mem_addr,
  output logic [0:3][7:0] mem_data_in,
  output logic            mem_write_en,
  output logic            mem_byte_mode,
  output logic            busy,
  output logic            grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

  state_t     state, state_next;
  logic [7:0] counter;
  logic       last_grant;
  logic       lat_write;
  logic       winner;
  logic       any_req;
  logic       final_cycle;

  assign any_req     = i_req || d_req;
  assign final_cycle = (state == ACCESS) && (counter == 8'd0);

  // On a tie the port that did not win last time gets the memory.
  assign winner = (i_req && d_req) ? ~last_grant : d_req;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (counter == 8'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter         <= 8'd0;
      last_grant      <= 1'b1;
      grant           <= 1'b0;
      lat_write       <= 1'b0;
      output_mem_addr <= 32'd0;
      mem_data_in     <= '0;
      mem_byte_mode   <= 1'b0;
      i_data_out      <= '0;
      d_data_out      <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant      <= winner;
        last_grant <= winner;
        counter    <= CNT_LOAD;
        if (winner) begin
          output_mem_addr <= d_addr;
          mem_data_in     <= d_data_in;
          mem_byte_mode   <= d_byte_mode;
          lat_write       <= d_write_enable;
        end else begin
          output_mem_addr <= i_addr;
          mem_data_in     <= '0;
          mem_byte_mode   <= 1'b0;
          lat_write       <= 1'b0;
        end
      end else if (state == ACCESS && counter != 8'd0) begin
        counter <= counter - 8'd1;
      end

      // Read data is taken on the last access cycle; a write leaves both ports alone.
      if (final_cycle && !lat_write) begin
        if (grant) d_data_out <= mem_data_out;
        else       i_data_out <= mem_data_out;
      end
    end
  end

  assign mem_write_en = final_cycle && lat_write && grant;
  assign i_ready      = (state == DONE) && !grant;
  assign d_ready      = (state == DONE) && grant;
  assign busy         = (state != IDLE);

endmodule
